// File: rtl/mem_arbiter_rr_pkg.sv
// rtl/mem_arbiter_rr_pkg.sv - shared encodings for the round-robin memory arbiter
package mem_arbiter_rr_pkg;

  localparam logic [1:0] RW_IDLE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  // A requester driving both bits is serviced as a write.
  function automatic logic [1:0] rw_normalize(input logic [1:0] flag);
    return flag[1] ? RW_WRITE : flag;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rtl/mem_arbiter_rr_pick.sv - round-robin pick: first requester at or after the pointer
module mem_arbiter_rr_pick #(
  parameter int NCH   = 2,
  parameter int IDX_W = 1
) (
  input  logic [NCH-1:0]   i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  logic [IDX_W-1:0] w_cand;

  // Scan from farthest to nearest so the candidate closest to the pointer is written last.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      w_cand = IDX_W'((int'(i_ptr) + k) % NCH);
      if (i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - N-channel round-robin memory arbiter (optional watchdog: MEM_ARB_TIMEOUT_EN)
module mem_arbiter_rr
  import mem_arbiter_rr_pkg::*;
#(
  parameter int NCH         = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2*NCH-1:0]          ch_rw_flag,
  input  logic [ADDR_W*NCH-1:0]     ch_addr,
  input  logic [DATA_W*NCH-1:0]     ch_wdata,
  input  logic [(DATA_W/8)*NCH-1:0] ch_wmask,
  output logic [DATA_W*NCH-1:0]     ch_rdata,
  output logic [NCH-1:0]            ch_busy,
  output logic [NCH-1:0]            ch_done,
  output logic [1:0]                mem_rw_flag,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic [DATA_W/8-1:0]       mem_wmask,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_busy,
  input  logic                      mem_done
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic [NCH-1:0]            ch_err
`endif
);

  localparam int MW    = DATA_W / 8;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

  arb_state_t           r_state;
  arb_state_t           w_next;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     r_gnt;
  logic [1:0]           r_flag;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic [MW-1:0]        r_wmask;
  logic [DATA_W*NCH-1:0] r_rdata;
  logic [NCH-1:0]       r_done;

  logic [NCH-1:0]       w_req;
  logic [IDX_W-1:0]     w_pick_idx;
  logic                 w_pick_valid;
  logic [IDX_W-1:0]     w_ptr_next;
  logic                 w_mem_done;
  logic                 w_timeout;

  // Any non-idle flag counts as a request.
  always_comb begin
    w_req = '0;
    for (int i = 0; i < NCH; i++) begin
      w_req[i] = |ch_rw_flag[2*i +: 2];
    end
  end

  mem_arbiter_rr_pick #(
    .NCH   (NCH),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  assign w_ptr_next = (r_gnt == LAST_IDX) ? '0 : r_gnt + 1'b1;
  assign w_mem_done = (r_state == ST_WAIT) && mem_done;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [NCH-1:0]   r_err;

  // A real completion in the same cycle as expiry wins over the timeout.
  assign w_timeout = (r_state == ST_WAIT) && !mem_done && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Watchdog counter: zero outside WAIT, counts WAIT cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (r_state != ST_WAIT) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Error pulse to the granted channel, aligned with its done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= '0;
    end else begin
      r_err <= '0;
      if (w_timeout) r_err[r_gnt] <= 1'b1;
    end
  end

  assign ch_err = r_err;
`else
  // Without the watchdog WAIT never expires.
  assign w_timeout = (TIMEOUT_CYC < 0);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_pick_valid)             w_next = ST_ISSUE;
      ST_ISSUE: if (!mem_busy)                w_next = ST_WAIT;
      ST_WAIT:  if (w_mem_done || w_timeout)  w_next = ST_IDLE;
      default:                                w_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state: busy to all channels, request only while issuing.
  always_comb begin
    ch_busy     = '0;
    mem_rw_flag = RW_IDLE;
    if (r_state != ST_IDLE)  ch_busy     = '1;
    if (r_state == ST_ISSUE) mem_rw_flag = r_flag;
  end

  // Datapath: latch the winner in IDLE, return data and rotate on completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_flag  <= RW_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_rdata <= '0;
      r_done  <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_gnt   <= w_pick_idx;
            r_flag  <= rw_normalize(ch_rw_flag[w_pick_idx*2 +: 2]);
            r_addr  <= ch_addr[w_pick_idx*ADDR_W +: ADDR_W];
            r_wdata <= ch_wdata[w_pick_idx*DATA_W +: DATA_W];
            r_wmask <= ch_wmask[w_pick_idx*MW +: MW];
          end
        end
        ST_WAIT: begin
          if (w_mem_done) begin
            if (r_flag == RW_READ) r_rdata[r_gnt*DATA_W +: DATA_W] <= mem_rdata;
            r_done[r_gnt] <= 1'b1;
            r_ptr         <= w_ptr_next;
          end else if (w_timeout) begin
            r_done[r_gnt] <= 1'b1;
            r_ptr         <= w_ptr_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wmask = r_wmask;
  assign ch_rdata  = r_rdata;
  assign ch_done   = r_done;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb/tb_mem_arbiter_rr.sv - scoreboard bench for mem_arbiter_rr (MEM_ARB_TIMEOUT_EN adds the watchdog test)
module tb_mem_arbiter_rr;

  localparam int NCH    = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MW     = DATA_W / 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [2*NCH-1:0]      ch_rw_flag = '0;
  logic [ADDR_W*NCH-1:0] ch_addr = '0;
  logic [DATA_W*NCH-1:0] ch_wdata = '0;
  logic [MW*NCH-1:0]     ch_wmask = '0;
  logic [DATA_W*NCH-1:0] ch_rdata;
  logic [NCH-1:0]        ch_busy;
  logic [NCH-1:0]        ch_done;
  logic [1:0]            mem_rw_flag;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [MW-1:0]         mem_wmask;
  logic [DATA_W-1:0]     mem_rdata = '0;
  logic                  mem_busy = 1'b0;
  logic                  mem_done = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
  logic [NCH-1:0]        ch_err;
`endif

  typedef struct {
    int          ch;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_rdata[NCH];
  int          n_tests = 0;
  int          n_fail  = 0;

  mem_arbiter_rr #(
    .NCH         (NCH),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_rw_flag  (ch_rw_flag),
    .ch_addr     (ch_addr),
    .ch_wdata    (ch_wdata),
    .ch_wmask    (ch_wmask),
    .ch_rdata    (ch_rdata),
    .ch_busy     (ch_busy),
    .ch_done     (ch_done),
    .mem_rw_flag (mem_rw_flag),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wmask   (mem_wmask),
    .mem_rdata   (mem_rdata),
    .mem_busy    (mem_busy),
    .mem_done    (mem_done)
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    .ch_err      (ch_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  // Completion monitor: every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && ch_done !== '0) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: ch_done=%b required 00", ch_done);
      end else begin
        e = sb_q.pop_front();
        if (ch_done !== NCH'(1 << e.ch)) begin
          n_fail++;
          $display("FAIL done_channel: ch_done=%b required channel %0d", ch_done, e.ch);
        end
        n_tests++;
        if (ch_rdata[e.ch*DATA_W +: DATA_W] !== e.rdata) begin
          n_fail++;
          $display("FAIL done_rdata ch%0d: got %h required %h", e.ch, ch_rdata[e.ch*DATA_W +: DATA_W], e.rdata);
        end
`ifdef MEM_ARB_TIMEOUT_EN
        n_tests++;
        if (ch_err !== (e.err ? NCH'(1 << e.ch) : NCH'(0))) begin
          n_fail++;
          $display("FAIL done_err ch%0d: ch_err=%b required err=%0d", e.ch, ch_err, e.err);
        end
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [1:0] flag, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask);
    ch_rw_flag[ch*2 +: 2]       = flag;
    ch_addr[ch*ADDR_W +: ADDR_W] = addr;
    ch_wdata[ch*DATA_W +: DATA_W] = wdata;
    ch_wmask[ch*MW +: MW]        = wmask;
  endtask

  task automatic wait_issue(input string tag);
    int n = 0;
    while (mem_rw_flag === 2'b00 && n < 20) begin
      tick();
      n++;
    end
    n_tests++;
    if (mem_rw_flag === 2'b00) begin
      n_fail++;
      $display("FAIL %s issue_wait: mem_rw_flag=%b required nonzero within 20 cycles", tag, mem_rw_flag);
    end
  endtask

  // Full zero-wait transaction on one channel; returns in the done cycle with the flag cleared.
  task automatic do_txn(input int ch, input logic [1:0] flag, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask, input logic [31:0] rdata);
    logic [1:0] exp_flag;
    exp_flag = flag[1] ? 2'b10 : flag;
    set_ch(ch, flag, addr, wdata, wmask);
    wait_issue("txn");
    n_tests++;
    if (mem_rw_flag !== exp_flag || mem_addr !== addr) begin
      n_fail++;
      $display("FAIL txn_issue ch%0d: flag=%b addr=%h required flag=%b addr=%h", ch, mem_rw_flag, mem_addr, exp_flag, addr);
    end
    if (exp_flag == 2'b10) begin
      n_tests++;
      if (mem_wdata !== wdata || mem_wmask !== wmask) begin
        n_fail++;
        $display("FAIL txn_wdata ch%0d: wdata=%h wmask=%b required %h %b", ch, mem_wdata, mem_wmask, wdata, wmask);
      end
    end
    tick();
    mem_done  = 1'b1;
    mem_rdata = rdata;
    if (exp_flag == 2'b01) model_rdata[ch] = rdata;
    sb_q.push_back('{ch: ch, rdata: model_rdata[ch], err: 1'b0});
    tick();
    mem_done = 1'b0;
    ch_rw_flag[ch*2 +: 2] = 2'b00;
  endtask

  task automatic apply_reset();
    rst        = 1'b0;
    ch_rw_flag = '0;
    mem_done   = 1'b0;
    mem_busy   = 1'b0;
    for (int i = 0; i < NCH; i++) model_rdata[i] = '0;
    sb_q.delete();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if (ch_busy !== '0 || ch_done !== '0 || ch_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_ch: busy=%b done=%b rdata=%h required zeros", ch_busy, ch_done, ch_rdata);
    end
    n_tests++;
    if (mem_rw_flag !== 2'b00 || mem_addr !== '0 || mem_wdata !== '0 || mem_wmask !== '0) begin
      n_fail++;
      $display("FAIL reset_mem: flag=%b addr=%h wdata=%h wmask=%b required zeros", mem_rw_flag, mem_addr, mem_wdata, mem_wmask);
    end
    apply_reset();
  endtask

  task automatic test_single_read();
    set_ch(1, 2'b01, 32'h100, 32'h0, 4'h0);
    n_tests++;
    if (mem_rw_flag !== 2'b00 || ch_busy !== 2'b00) begin
      n_fail++;
      $display("FAIL read_c0: flag=%b busy=%b required 00 00", mem_rw_flag, ch_busy);
    end
    tick();
    n_tests++;
    if (mem_rw_flag !== 2'b01 || mem_addr !== 32'h100 || ch_busy !== 2'b11) begin
      n_fail++;
      $display("FAIL read_c1: flag=%b addr=%h busy=%b required 01 100 11", mem_rw_flag, mem_addr, ch_busy);
    end
    tick();
    n_tests++;
    if (mem_rw_flag !== 2'b00 || ch_done !== 2'b00) begin
      n_fail++;
      $display("FAIL read_c2: flag=%b done=%b required 00 00", mem_rw_flag, ch_done);
    end
    mem_done  = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    model_rdata[1] = 32'hDEADBEEF;
    sb_q.push_back('{ch: 1, rdata: 32'hDEADBEEF, err: 1'b0});
    tick();
    mem_done = 1'b0;
    ch_rw_flag = '0;
    n_tests++;
    if (ch_done !== 2'b10 || ch_busy !== 2'b00) begin
      n_fail++;
      $display("FAIL read_c3: done=%b busy=%b required 10 00", ch_done, ch_busy);
    end
    tick();
  endtask

  task automatic test_contention();
    logic [31:0] addrs[2];
    logic [31:0] d;
    int g;
    addrs[0] = 32'hA0;
    addrs[1] = 32'hB0;
    apply_reset();
    set_ch(0, 2'b01, addrs[0], 32'h0, 4'h0);
    set_ch(1, 2'b01, addrs[1], 32'h0, 4'h0);
    for (int r = 0; r < 4; r++) begin
      g = r % 2;
      wait_issue("contention");
      n_tests++;
      if (mem_addr !== addrs[g]) begin
        n_fail++;
        $display("FAIL contention_grant%0d: addr=%h required %h", r, mem_addr, addrs[g]);
      end
      tick();
      d = 32'h1000 + r;
      mem_done  = 1'b1;
      mem_rdata = d;
      model_rdata[g] = d;
      sb_q.push_back('{ch: g, rdata: d, err: 1'b0});
      tick();
      mem_done = 1'b0;
      if (r == 3) ch_rw_flag = '0;
    end
    tick();
  endtask

  task automatic test_backpressure();
    set_ch(0, 2'b01, 32'h200, 32'h0, 4'h0);
    mem_busy = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i == 2) ch_addr[0 +: ADDR_W] = 32'h999;
      if (i == 5) mem_busy = 1'b0;
      n_tests++;
      if (mem_rw_flag !== 2'b01 || mem_addr !== 32'h200 || ch_busy !== 2'b11) begin
        n_fail++;
        $display("FAIL backpressure_c%0d: flag=%b addr=%h busy=%b required 01 200 11", i, mem_rw_flag, mem_addr, ch_busy);
      end
      tick();
    end
    n_tests++;
    if (mem_rw_flag !== 2'b00 || ch_busy !== 2'b11) begin
      n_fail++;
      $display("FAIL backpressure_wait: flag=%b busy=%b required 00 11", mem_rw_flag, ch_busy);
    end
    mem_done  = 1'b1;
    mem_rdata = 32'h0BADF00D;
    model_rdata[0] = 32'h0BADF00D;
    sb_q.push_back('{ch: 0, rdata: 32'h0BADF00D, err: 1'b0});
    tick();
    mem_done = 1'b0;
    ch_rw_flag = '0;
    tick();
  endtask

  task automatic test_write();
    do_txn(0, 2'b10, 32'h300, 32'h12345678, 4'b0011, 32'hFFFFFFFF);
    tick();
    do_txn(1, 2'b11, 32'h304, 32'hCAFEF00D, 4'b1100, 32'h55555555);
    tick();
  endtask

  task automatic test_reset_mid_wait();
    do_txn(0, 2'b01, 32'h400, 32'h0, 4'h0, 32'h44440000);
    tick();
    set_ch(1, 2'b01, 32'h404, 32'h0, 4'h0);
    wait_issue("abort");
    tick();
    rst = 1'b0;
    #1;
    n_tests++;
    if (ch_busy !== '0 || ch_done !== '0 || ch_rdata !== '0 || mem_rw_flag !== 2'b00 || mem_addr !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: busy=%b done=%b rdata=%h flag=%b addr=%h required zeros", ch_busy, ch_done, ch_rdata, mem_rw_flag, mem_addr);
    end
    ch_rw_flag = '0;
    for (int i = 0; i < NCH; i++) model_rdata[i] = '0;
    tick();
    rst = 1'b1;
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    tick();
    n_tests++;
    if (ch_done !== 2'b00 || ch_busy !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_stray_done: done=%b busy=%b required 00 00", ch_done, ch_busy);
    end
    set_ch(0, 2'b01, 32'h500, 32'h0, 4'h0);
    set_ch(1, 2'b01, 32'h504, 32'h0, 4'h0);
    wait_issue("abort_ptr");
    n_tests++;
    if (mem_addr !== 32'h500) begin
      n_fail++;
      $display("FAIL abort_ptr: addr=%h required 500 (pointer back at 0)", mem_addr);
    end
    tick();
    mem_done  = 1'b1;
    mem_rdata = 32'h50505050;
    model_rdata[0] = 32'h50505050;
    sb_q.push_back('{ch: 0, rdata: 32'h50505050, err: 1'b0});
    tick();
    mem_done = 1'b0;
    ch_rw_flag = '0;
    tick();
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_txn(1, 2'b01, 32'h600, 32'h0, 4'h0, 32'h66660000);
    tick();
    set_ch(0, 2'b01, 32'h700, 32'h0, 4'h0);
    wait_issue("timeout");
    tick();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (ch_done !== 2'b00 || ch_err !== 2'b00) begin
        n_fail++;
        $display("FAIL timeout_early_w%0d: done=%b err=%b required 00 00", i, ch_done, ch_err);
      end
      if (i == 3) sb_q.push_back('{ch: 0, rdata: model_rdata[0], err: 1'b1});
      tick();
    end
    n_tests++;
    if (ch_done !== 2'b01 || ch_err !== 2'b01) begin
      n_fail++;
      $display("FAIL timeout_pulse: done=%b err=%b required 01 01", ch_done, ch_err);
    end
    mem_done  = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    set_ch(1, 2'b01, 32'h704, 32'h0, 4'h0);
    tick();
    mem_done = 1'b0;
    wait_issue("timeout_next");
    n_tests++;
    if (mem_addr !== 32'h704) begin
      n_fail++;
      $display("FAIL timeout_next_grant: addr=%h required 704", mem_addr);
    end
    tick();
    mem_done  = 1'b1;
    mem_rdata = 32'h77770000;
    model_rdata[1] = 32'h77770000;
    sb_q.push_back('{ch: 1, rdata: 32'h77770000, err: 1'b0});
    tick();
    mem_done = 1'b0;
    ch_rw_flag = '0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_backpressure();
    test_write();
    test_reset_mid_wait();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    tick();
    tick();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_done: %0d completions outstanding, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
Parametrised N-channel memory arbiter that replaces the fixed two-channel (I-cache/D-cache) split of the external memory bus with one shared memory port. Sits between the cache instances inside the CPU top and the memory controller. Grants one outstanding transaction at a time using round-robin fairness, and routes the read data and completion back to the requesting channel.

Parameters:
NCH, 2, number of requesting channels (1..8).
ADDR_W, 32, address width.
DATA_W, 32, data width; must be a multiple of 8.
TIMEOUT_CYC, 255, watchdog limit in cycles; used only with MEM_ARB_TIMEOUT_EN.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous assert, active-low (0 = reset).
ch_rw_flag  in  2*NCH  per channel: bit0 = read, bit1 = write; 00 = idle; 11 treated as write.
ch_addr  in  ADDR_W*NCH  per-channel address.
ch_wdata  in  DATA_W*NCH  per-channel write data.
ch_wmask  in  (DATA_W/8)*NCH  per-channel byte-enable mask.
ch_rdata  out  DATA_W*NCH  per-channel read data, registered.
ch_busy  out  NCH  shared port occupied.
ch_done  out  NCH  one-cycle completion pulse.
mem_rw_flag  out  2  memory-side request.
mem_addr  out  ADDR_W  memory-side address.
mem_wdata  out  DATA_W  memory-side write data.
mem_wmask  out  DATA_W/8  memory-side byte mask.
mem_rdata  in  DATA_W  memory-side read data.
mem_busy  in  1  memory cannot accept a request.
mem_done  in  1  memory completion pulse.
ch_err  out  NCH  timeout error pulse; present only with MEM_ARB_TIMEOUT_EN.

Behaviour:
- Reset (rst=0, async): state=IDLE, rr pointer=0, all outputs 0, including ch_rdata and mem_*.
- FSM states:
  - IDLE: if any ch_rw_flag!=0, select the first requesting channel at or after the pointer (wrapping modulo NCH). Latch its index, flag, addr, wdata and wmask. Go to ISSUE.
  - ISSUE: mem_rw_flag and mem_addr/wdata/wmask are driven from the latched values. On a cycle where mem_busy=0 the request is accepted; go to WAIT, and mem_rw_flag returns to 00 from the next cycle. While mem_busy=1, stay in ISSUE holding the request.
  - WAIT: on mem_done=1:
    - for a read, ch_rdata[g] <= mem_rdata; for a write, ch_rdata is unchanged;
    - ch_done[g] pulses high on the next cycle;
    - pointer <= (g+1) mod NCH;
    - go to IDLE.
- ch_busy[i] = 1 for every i whenever state != IDLE.
- Minimum latency: request seen in IDLE at cycle 0 → ISSUE at cycle 1 → WAIT at cycle 2 → mem_done at cycle 2 → ch_done at cycle 3.
- Requesters hold ch_rw_flag until ch_done. They must clear it in the cycle after ch_done, or it is treated as a new request; the rotated pointer keeps this fair.
- Requests arriving during ISSUE/WAIT are ignored until the FSM returns to IDLE.
- Channel inputs are not re-sampled after latch.
- mem_done outside WAIT is ignored.
- Reset mid-transaction abandons it: no ch_done, and any later mem_done is ignored.
- NCH=1: pointer is constant 0.

Optional Feature:
MEM_ARB_TIMEOUT_EN:
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT_CYC without mem_done:
  - ch_done[g] and ch_err[g] pulse together;
  - ch_rdata[g] is unchanged;
  - pointer rotates and the FSM goes to IDLE.
- A late mem_done is ignored.
- Undefined: no counter and no ch_err port; WAIT lasts indefinitely.

Decomposition:
- Shared defines file: rw-flag encodings (RW_IDLE 00, RW_READ 01, RW_WRITE 10) and FSM state encodings.
- One combinational sub-module, rr_pick (NCH-wide request vector + pointer → grant index + valid).

Test Plan:
1. Single read: ch1 rw=01, addr=0x100; mem_busy=0; mem_done at cycle 2 with rdata=0xDEADBEEF → ch_rdata[1]=0xDEADBEEF, ch_done[1] at cycle 3, mem_rw_flag=01 only in cycle 1.
2. Contention: ch0 and ch1 both hold reads from reset → grant order 0,1,0,1; each ch_done pulses once per grant.
3. Backpressure: mem_busy=1 for 5 cycles in ISSUE → mem_rw_flag/addr held stable for 6 cycles, ch_busy=all-ones throughout.
4. Write: ch0 rw=10, wdata=0x12345678, wmask=4'b0011 → mem_wdata/mem_wmask match; ch_done[0] pulses; ch_rdata[0] unchanged.
5. Reset mid-WAIT, then a stray mem_done → all outputs 0, no ch_done, FSM in IDLE, pointer 0.
6. (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYC=4) no mem_done → ch_done[g] and ch_err[g] pulse 4 cycles after WAIT entry; next grant goes to channel g+1.
